sign_narrow16_4: RTL and testbench

- Inverse of the 4→16 immediate sign extender: narrows 16-bit two's-complement words to 4-bit signed immediates for the instruction-packing and immediate-encode path.
- Flags every value that does not fit in 4 bits.
- Buffers results in a 2-entry output queue with valid/ready handshakes on both sides.
- Keeps a saturating count of overflowed values for debug.

---
 rtl/narrow_defs.sv | 25 ++
 rtl/narrow_fifo2.sv | 74 +++++++
 rtl/sign_narrow16_4.sv | 105 ++++++++++
 tb/tb_sign_narrow16_4.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/narrow_defs.sv
// rtl/narrow_defs.sv - shared widths, saturation limits and queue entry layout
//
// Purpose : default widths for the 16->4 signed narrower, the signed range
//           limits of the narrowed immediate and the {ovf, imm} queue entry
//           layout used between the narrowing logic and its output queue.
// Ports   : none (package).
package narrow_defs;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 4;
  localparam int DEF_CNT_W = 8;

  // Representable range of a DEF_OUT_W-bit two's-complement immediate.
  localparam int OUT_MAX = (1 << (DEF_OUT_W - 1)) - 1;
  localparam int OUT_MIN = -(1 << (DEF_OUT_W - 1));

  // Queue entry: overflow flag above the narrowed immediate.
  localparam int ENTRY_W = DEF_OUT_W + 1;

  typedef struct packed {
    logic                 ovf;
    logic [DEF_OUT_W-1:0] imm;
  } entry_t;

endpackage

// File: rtl/narrow_fifo2.sv
// rtl/narrow_fifo2.sv - generic 2-entry valid/ready FIFO with registered entries
//
// Purpose : two-deep FIFO. The head entry drives out_data directly from a
//           register. in_ready depends only on the registered occupancy, so
//           there is no combinational path from out_ready to in_ready.
// Ports   : clk, reset (sync, active-high)
//           in_valid / in_ready / in_data   - write side
//           out_valid / out_ready / out_data - read side (head entry)
module narrow_fifo2 #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Push and pop together leave occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Entries are cleared so the head reads as zero straight out of reset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sign_narrow16_4.sv
// rtl/sign_narrow16_4.sv - narrows 16-bit signed words to 4-bit immediates with overflow flag
//
// Purpose : fit-tests each input word against the OUT_W-bit signed range,
//           narrows it (truncation, or saturation when NARROW_SAT_EN is
//           defined), queues {ovf, imm} in a 2-entry FIFO and keeps a
//           saturating count of accepted overflowed words.
// Macro   : NARROW_SAT_EN - saturate out-of-range values instead of truncating.
// Ports   : clk, reset (sync, active-high)
//           in_valid / in_ready / in_word         - input stream
//           out_valid / out_ready / out_imm / out_ovf - narrowed output stream
//           ovf_count - saturating overflow count; clr_count - sync clear
module sign_narrow16_4
  import narrow_defs::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_count
);

  localparam int EW = OUT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Bits from the top down to the narrowed sign bit; the word fits only if
  // they are all copies of the sign.
  logic [IN_W-OUT_W:0] upper_bits;
  logic                fit;
  logic [OUT_W-1:0]    narrow_imm;
  logic [EW-1:0]       in_entry;
  logic [EW-1:0]       head_entry;
  logic                in_xfer;
  logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;

  assign upper_bits = in_word[IN_W-1:OUT_W-1];
  assign fit        = (&upper_bits) | ~(|upper_bits);

`ifdef NARROW_SAT_EN
  localparam logic [OUT_W-1:0] SAT_MAX = OUT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic [OUT_W-1:0] SAT_MIN = OUT_W'(1 << (OUT_W - 1));

  // Overflow direction follows the sign of the full-width word.
  always_comb begin
    narrow_imm = in_word[OUT_W-1:0];
    if (!fit) begin
      narrow_imm = in_word[IN_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  always_comb begin
    narrow_imm = in_word[OUT_W-1:0];
  end
`endif

  assign in_entry = {~fit, narrow_imm};

  narrow_fifo2 #(
    .W(EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_entry)
  );

  assign out_ovf = head_entry[EW-1];
  assign out_imm = head_entry[OUT_W-1:0];

  assign in_xfer = in_valid & in_ready;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clr_count) begin
      ovf_cnt_d = '0;
    end else if (in_xfer && !fit && (ovf_cnt_q != CNT_MAX)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_sign_narrow16_4.sv
// tb/tb_sign_narrow16_4.sv - randomized and directed bench for sign_narrow16_4 against a queue model
module tb_sign_narrow16_4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_imm;
  logic        out_ovf;
  logic [7:0]  ovf_count;
  logic        clr_count;

  always #5 clk = ~clk;

  sign_narrow16_4 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_ovf   (out_ovf),
    .ovf_count (ovf_count),
    .clr_count (clr_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;
  int exp_cnt  = 0;
  logic [4:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  // Expected {ovf, imm} from the signed value of the word.
  function automatic logic [4:0] ref_entry(input logic [15:0] w);
    int v;
    bit ovf;
    int imm;
    v   = $signed(w);
    ovf = (v > 7) || (v < -8);
`ifdef NARROW_SAT_EN
    imm = ovf ? ((v > 7) ? 7 : 8) : (v & 15);
`else
    imm = v & 15;
`endif
    return {ovf, 4'(imm)};
  endfunction

  // Entered and left at a falling edge: check current state, drive, clock, update model.
  task automatic cycle(input bit iv, input logic [15:0] w, input bit ordy, input bit clr, input bit rst);
    bit push;
    bit pop;
    logic [4:0] e;
    check_eq("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check_eq("out_imm", out_imm, exp_q[0][3:0]);
      check_eq("out_ovf", out_ovf, exp_q[0][4]);
    end
    check_eq("in_ready", in_ready, exp_q.size() < 2);
    check_eq("ovf_count", ovf_count, exp_cnt);
    in_valid  = iv;
    in_word   = w;
    out_ready = ordy;
    clr_count = clr;
    reset     = rst;
    push = iv && (exp_q.size() < 2);
    pop  = ordy && (exp_q.size() != 0);
    e    = ref_entry(w);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        n_pops++;
      end
      if (push) exp_q.push_back(e);
      if (clr) exp_cnt = 0;
      else if (push && e[4] && exp_cnt < 255) exp_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (3) cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [15:0] rand_word();
    int sel;
    int v;
    sel = $urandom_range(0, 2);
    if (sel == 0) begin
      v = int'($urandom_range(0, 20)) - 10;
      return 16'(v);
    end else if (sel == 1) begin
      case ($urandom_range(0, 5))
        0: return 16'h0007;
        1: return 16'h0008;
        2: return 16'hFFF8;
        3: return 16'hFFF7;
        4: return 16'h7FFF;
        default: return 16'h8000;
      endcase
    end
    return 16'($urandom);
  endfunction

  initial begin
    int p0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;
    clr_count = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state
    check_eq("rst_imm", out_imm, 4'h0);
    check_eq("rst_ovf", out_ovf, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);

    // In-range values, one cycle latency
    cycle(1'b1, 16'hFFFD, 1'b1, 1'b0, 1'b0);
    check_eq("t1_imm0", out_imm, 4'hD);
    check_eq("t1_ovf0", out_ovf, 1'b0);
    cycle(1'b1, 16'h0007, 1'b1, 1'b0, 1'b0);
    check_eq("t1_imm1", out_imm, 4'h7);
    check_eq("t1_cnt", ovf_count, 8'd0);
    drain();

    // Overflow values
    cycle(1'b1, 16'h0008, 1'b1, 1'b0, 1'b0);
`ifdef NARROW_SAT_EN
    check_eq("ovf_pos_imm", out_imm, 4'h7);
`else
    check_eq("ovf_pos_imm", out_imm, 4'h8);
`endif
    check_eq("ovf_pos_flag", out_ovf, 1'b1);
    cycle(1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
`ifdef NARROW_SAT_EN
    check_eq("ovf_neg_imm", out_imm, 4'h8);
`else
    check_eq("ovf_neg_imm", out_imm, 4'h0);
`endif
    check_eq("ovf_neg_flag", out_ovf, 1'b1);
    check_eq("ovf_cnt2", ovf_count, 8'd2);
    drain();

    // Backpressure
    cycle(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    check_eq("bp_in_ready", in_ready, 1'b0);
    repeat (2) begin
      cycle(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
      check_eq("bp_head", out_imm, 4'h1);
    end
    cycle(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
    check_eq("bp_out2", out_imm, 4'h2);
    cycle(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
    check_eq("bp_out3", out_imm, 4'h3);
    drain();

    // Continuous push/pop throughput
    p0 = n_pops;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
      check_eq("tp_in_ready", in_ready, 1'b1);
    end
    check_eq("tp_pops", n_pops - p0, 9);
    drain();

    // Counter saturation and clear priority
    repeat (300) cycle(1'b1, 16'h4000, 1'b1, 1'b0, 1'b0);
    check_eq("cnt_sat", ovf_count, 8'd255);
    cycle(1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
    check_eq("cnt_clr", ovf_count, 8'd0);
    drain();

    // Reset with two entries queued
    cycle(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    check_eq("mr_cnt_pre", ovf_count, 8'd1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    check_eq("mr_out_valid", out_valid, 1'b0);
    check_eq("mr_in_ready", in_ready, 1'b1);
    check_eq("mr_cnt", ovf_count, 8'd0);
    cycle(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
    check_eq("mr_imm", out_imm, 4'h3);
    check_eq("mr_valid", out_valid, 1'b1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
